// File: rtl/debounce_pkg.sv
// Shared types and helpers for the switch/button conditioner array.
// Holds the per-channel state encoding and width helpers used for counter sizing.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } ch_state_e;

    // Counter width helper: never returns 0, so single-state counters still get one bit.
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioned channel: 2-flop synchroniser, stable-time filter, press/hold/repeat FSM.
// Every tick is registered on the same edge that updates sw_out.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int FILTER_N = 20,
    parameter int HOLD_N   = 1000,
    parameter int REPEAT_N = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic smp,
    input  logic raw,
    input  logic inv,
    output logic sw_out,
    output logic rise_tick,
    output logic fall_tick,
    output logic hold_tick,
    output logic rpt_tick
);

    localparam int FW = clog2_safe(FILTER_N + 1);
    localparam int HW = clog2_safe(max2(HOLD_N, REPEAT_N) + 1);
    localparam logic [FW-1:0] F_LOAD = FW'(FILTER_N - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_N - 1);
    localparam logic [HW-1:0] R_LAST = HW'((REPEAT_N > 0) ? REPEAT_N - 1 : 0);
    localparam bit            RPT_EN = (REPEAT_N > 0);

    logic [1:0]    sync_pipe;
    logic          x;
    logic [FW-1:0] fcnt, fcnt_d;
    logic          commit;
    ch_state_e     state, state_d;
    logic [HW-1:0] hcnt, hcnt_d;
    logic          hold_d, rpt_d;

    assign x = sync_pipe[1] ^ inv;

    // A commit always flips sw_out, so x carries the new level whenever commit is set.
    always_comb begin
        fcnt_d = fcnt;
        commit = 1'b0;
        if (smp) begin
            if (x == sw_out) begin
                fcnt_d = F_LOAD;
            end else if (fcnt == '0) begin
                commit = 1'b1;
                fcnt_d = F_LOAD;
            end else begin
                fcnt_d = fcnt - 1'b1;
            end
        end
    end

    // A release commit is checked ahead of the hold/repeat terminal count, so it suppresses them.
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        hold_d  = 1'b0;
        rpt_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (commit && x) begin
                    state_d = PRESS;
                    hcnt_d  = '0;
                end
            end
            PRESS: begin
                if (commit) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end else if (smp) begin
                    if (hcnt == H_LAST) begin
                        hold_d  = 1'b1;
                        hcnt_d  = '0;
                        state_d = HELD;
                    end else begin
                        hcnt_d = hcnt + 1'b1;
                    end
                end
            end
            HELD: begin
                if (commit) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end else if (smp && RPT_EN) begin
                    if (hcnt == R_LAST) begin
                        rpt_d  = 1'b1;
                        hcnt_d = '0;
                    end else begin
                        hcnt_d = hcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_pipe <= '0;
            fcnt      <= F_LOAD;
            hcnt      <= '0;
            sw_out    <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            hold_tick <= 1'b0;
            rpt_tick  <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], raw};
            fcnt      <= fcnt_d;
            hcnt      <= hcnt_d;
            if (commit) begin
                sw_out <= x;
            end
            rise_tick <= commit & x;
            fall_tick <= commit & ~x;
            hold_tick <= hold_d;
            rpt_tick  <= rpt_d;
        end
    end

endmodule

// File: rtl/debounce_array.sv
// N-channel switch conditioner: one shared sample-strobe prescaler feeding CH debounce_ch lanes.
// any_rise is a plain OR of the registered rise ticks, so it pulses in the same cycle.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int            CH       = 4,
    parameter int            CLK_DIV  = 100_000,
    parameter int            FILTER_N = 20,
    parameter int            HOLD_N   = 1000,
    parameter int            REPEAT_N = 200,
    parameter logic [CH-1:0] INV_MASK = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] sw_in,
    output logic [CH-1:0] sw_out,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick,
    output logic [CH-1:0] hold_tick,
    output logic [CH-1:0] rpt_tick,
    output logic          any_rise
);

    localparam int            PW     = clog2_safe(CLK_DIV);
    localparam logic [PW-1:0] P_LOAD = PW'(CLK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic          smp;

    assign smp = (pcnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= P_LOAD;
        end else if (smp) begin
            pcnt <= P_LOAD;
        end else begin
            pcnt <= pcnt - 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            debounce_ch #(
                .FILTER_N(FILTER_N),
                .HOLD_N  (HOLD_N),
                .REPEAT_N(REPEAT_N)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .smp      (smp),
                .raw      (sw_in[i]),
                .inv      (INV_MASK[i]),
                .sw_out   (sw_out[i]),
                .rise_tick(rise_tick[i]),
                .fall_tick(fall_tick[i]),
                .hold_tick(hold_tick[i]),
                .rpt_tick (rpt_tick[i])
            );
        end
    endgenerate

    assign any_rise = |rise_tick;

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array (CH=2, CLK_DIV=4, FILTER_N=3, HOLD_N=8, REPEAT_N=4).
// Edges are counted from reset release; strobes land on edges 4,8,12,...
module tb_debounce_array;

    localparam int            CH       = 2;
    localparam int            CLK_DIV  = 4;
    localparam int            FILTER_N = 3;
    localparam int            HOLD_N   = 8;
    localparam int            REPEAT_N = 4;
    localparam logic [CH-1:0] INV_MASK = 2'b10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] sw_in = 2'b10;
    logic [CH-1:0] sw_out, rise_tick, fall_tick, hold_tick, rpt_tick;
    logic          any_rise;

    typedef struct {
        int            edge_n;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] hold;
        logic [CH-1:0] rpt;
        logic [CH-1:0] sw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;

    debounce_array #(
        .CH(CH), .CLK_DIV(CLK_DIV), .FILTER_N(FILTER_N),
        .HOLD_N(HOLD_N), .REPEAT_N(REPEAT_N), .INV_MASK(INV_MASK)
    ) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .sw_out(sw_out),
        .rise_tick(rise_tick), .fall_tick(fall_tick), .hold_tick(hold_tick),
        .rpt_tick(rpt_tick), .any_rise(any_rise)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic push(input int e, input logic [CH-1:0] r, input logic [CH-1:0] f,
                        input logic [CH-1:0] h, input logic [CH-1:0] p, input logic [CH-1:0] s);
        exp_t x;
        x.edge_n = e; x.rise = r; x.fall = f; x.hold = h; x.rpt = p; x.sw = s;
        q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_sw_out"}, 32'(sw_out), 0);
        check({name, "_ticks"}, 32'({rise_tick, fall_tick, hold_tick, rpt_tick}), 0);
        check({name, "_any_rise"}, 32'(any_rise), 0);
    endtask

    // Returns at the negedge following posedge e; bounded so a stuck clock cannot hang the run.
    task automatic at_edge(input int e);
        int n = 0;
        while (ecnt < e && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (ecnt != e) begin
            checks++;
            errors++;
            $display("FAIL at_edge actual=%0d required=%0d", ecnt, e);
        end
    endtask

    // Any cycle showing a tick must match the head of the expected-event queue.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && ((|{rise_tick, fall_tick, hold_tick, rpt_tick}) || any_rise)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick edge=%0d rise=%b fall=%b hold=%b rpt=%b any=%b",
                             ecnt, rise_tick, fall_tick, hold_tick, rpt_tick, any_rise);
                end else begin
                    e = q.pop_front();
                    if (ecnt != e.edge_n || rise_tick !== e.rise || fall_tick !== e.fall ||
                        hold_tick !== e.hold || rpt_tick !== e.rpt || sw_out !== e.sw ||
                        any_rise !== (|e.rise)) begin
                        errors++;
                        $display("FAIL tick_event actual edge=%0d rise=%b fall=%b hold=%b rpt=%b sw=%b any=%b required edge=%0d rise=%b fall=%b hold=%b rpt=%b sw=%b any=%b",
                                 ecnt, rise_tick, fall_tick, hold_tick, rpt_tick, sw_out, any_rise,
                                 e.edge_n, e.rise, e.fall, e.hold, e.rpt, e.sw, |e.rise);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset state; ch1 pad idles high (active-low), ch0 idles low.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Clean press then long hold: commit 24, hold 56, repeats 72/88/104, release commit 116.
        at_edge(10);
        sw_in[0] = 1'b1;
        push(24,  2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
        push(56,  2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
        push(72,  2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
        push(88,  2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
        push(104, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
        at_edge(102);
        sw_in[0] = 1'b0;
        push(116, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

        at_edge(140);
        check("inv_idle_sw_out", 32'(sw_out), 0);

        // Bounce: 6-clk half periods never give 3 consecutive disagreeing strobes.
        for (int k = 0; k < 34; k++) begin
            at_edge(140 + 6 * k);
            sw_in[0] = (k % 2 == 0);
        end
        at_edge(344);
        check("bounce_sw_out", 32'(sw_out), 0);
        sw_in[0] = 1'b1;
        push(356, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);

        // Release commit lands on edge 388, the strobe that would have fired hold_tick.
        at_edge(376);
        sw_in[0] = 1'b0;
        push(388, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

        // Inverted channel: pad low is pressed.
        at_edge(400);
        sw_in[1] = 1'b0;
        push(412, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
        at_edge(420);
        sw_in[1] = 1'b1;
        push(432, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);

        // Both channels pressed together, then held.
        at_edge(440);
        sw_in = 2'b01;
        push(452, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
        push(484, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11);

        // Async reset in HELD, between clock edges.
        at_edge(490);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        check("queue_drained_before_reset", 32'(q.size()), 0);
        repeat (4) @(negedge clk);
        push(12, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
        reset = 1'b1;
        at_edge(30);
        check("post_reset_sw_out", 32'(sw_out), 32'(2'b11));
        check("queue_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
